// File: rtl/gray_monitor.sv
// gray_monitor
//   Receive-side checker that sits beside a Gray-code counter. Every clock it
//   samples the counter's Gray output, decodes it to binary and checks that
//   the step matches the counter's enable as seen one edge earlier. Legal
//   wraps (max -> 0) are reported as a one-cycle pulse and counted with
//   saturation. Any illegal transition parks the monitor in a sticky error
//   state that only Clear or Reset can leave.
//
// Ports
//   Clk        in   1       rising-edge clock shared with the counter
//   Reset      in   1       asynchronous, active-high reset
//   En         in   1       the counter's own enable
//   Gray       in   WIDTH   the counter's registered Gray output
//   Clear      in   1       synchronous resync (wired to the counter's reset request)
//   Binary     out  WIDTH   registered decode of the last Gray sample
//   Wrap       out  1       one-cycle pulse on a legal max -> 0 step
//   WrapCount  out  WRAP_W  legal wraps since Reset/Clear, saturating
//   Locked     out  1       high while in TRACK
//   Error      out  1       high while in ERROR (sticky)
//   dbg_state  out  2       current FSM state (0 IDLE, 1 TRACK, 2 ERROR)
//
// Handshake: none. Every input is sampled on every rising edge of Clk;
// there is no valid/ready pair, the monitor simply observes the counter.
module gray_monitor #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  Gray,
  input  logic              Clear,
  output logic [WIDTH-1:0]  Binary,
  output logic              Wrap,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Locked,
  output logic              Error,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  BIN_MAX = '1;
  localparam logic [WRAP_W-1:0] WC_MAX  = '1;

  state_t           state;
  logic             en_q;
  logic [WIDTH-1:0] pb;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] pb_inc;
  logic             step_ok;

  // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
  // Shifting right drops the bits below i, so a reduction XOR gives it
  // directly without a bit-to-bit dependency chain.
  always_comb begin
    nb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nb[i] = ^(Gray >> i);
    end
  end

  assign pb_inc = pb + WIDTH'(1);

  // The sample at this edge is judged against the enable from the previous
  // edge: the counter only moves one edge after its enable was high.
  assign step_ok = en_q ? (nb == pb_inc) : (nb == pb);

  assign dbg_state = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      en_q      <= 1'b0;
      pb        <= '0;
      Binary    <= '0;
      Wrap      <= 1'b0;
      WrapCount <= '0;
      Locked    <= 1'b0;
      Error     <= 1'b0;
    end else begin
      en_q   <= En;
      Binary <= nb;
      Wrap   <= 1'b0;
      if (Clear) begin
        state     <= ST_IDLE;
        WrapCount <= '0;
        Error     <= 1'b0;
        Locked    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Relock on whatever the counter shows now; nothing to compare yet.
            pb     <= nb;
            state  <= ST_TRACK;
            Locked <= 1'b1;
          end
          ST_TRACK: begin
            if (step_ok) begin
              pb <= nb;
              if (en_q && (pb == BIN_MAX)) begin
                Wrap <= 1'b1;
                if (WrapCount != WC_MAX) begin
                  WrapCount <= WrapCount + WRAP_W'(1);
                end
              end
            end else begin
              state  <= ST_ERROR;
              Error  <= 1'b1;
              Locked <= 1'b0;
            end
          end
          ST_ERROR: begin
            // pb and WrapCount stay frozen; Binary keeps following the decode.
            Error  <= 1'b1;
            Locked <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            Error  <= 1'b0;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor
//   Directed bench for gray_monitor (WIDTH=3, WRAP_W=8). A behavioural Gray
//   counter (cnt) drives Gray; expected outputs are pushed to exp_q as each
//   step is driven and popped/compared 1 ns after the clock edge.
//   Expected entry layout: {binary[2:0], wrap, wrap_count[7:0], locked, error}.
module tb_gray_monitor;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Gray;
  logic       Clear;
  logic [2:0] Binary;
  logic       Wrap;
  logic [7:0] WrapCount;
  logic       Locked;
  logic       Error;
  logic [1:0] dbg_state;

  logic [2:0] cnt;        // behavioural counter value (binary)
  logic [2:0] last;       // last value the monitor should have accepted
  logic [7:0] exp_wc;     // expected wrap count
  int         checks;
  int         errors;
  logic [13:0] exp_q[$];

  assign Gray = cnt ^ (cnt >> 1);

  gray_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .Gray      (Gray),
    .Clear     (Clear),
    .Binary    (Binary),
    .Wrap      (Wrap),
    .WrapCount (WrapCount),
    .Locked    (Locked),
    .Error     (Error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #2 Clk = ~Clk;

  // ---------------- scoreboard ----------------
  function automatic logic [13:0] pack(input logic [2:0] b, input logic w,
                                       input logic [7:0] c, input logic l,
                                       input logic e);
    return {b, w, c, l, e};
  endfunction

  task automatic check_out();
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL queue: got empty queue, required one expected entry");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (Binary === e[13:11]) else begin
      errors++;
      $error("FAIL binary: got %0d required %0d", Binary, e[13:11]);
    end
    checks++;
    assert (Wrap === e[10]) else begin
      errors++;
      $error("FAIL wrap: got %0b required %0b (binary %0d)", Wrap, e[10], Binary);
    end
    checks++;
    assert (WrapCount === e[9:2]) else begin
      errors++;
      $error("FAIL wrap_count: got %0d required %0d", WrapCount, e[9:2]);
    end
    checks++;
    assert (Locked === e[1]) else begin
      errors++;
      $error("FAIL locked: got %0b required %0b", Locked, e[1]);
    end
    checks++;
    assert (Error === e[0]) else begin
      errors++;
      $error("FAIL error: got %0b required %0b", Error, e[0]);
    end
  endtask

  // Compare without waiting for a clock edge (async reset checks).
  task automatic check_now(input logic [13:0] e);
    exp_q.push_back(e);
    check_out();
  endtask

  // ---------------- driver ----------------
  // Drive one edge; the counter model moves after the edge like a real
  // registered counter (Clear acts as its reset request).
  task automatic drive_step(input logic en, input logic clr, input logic [13:0] e);
    En    = en;
    Clear = clr;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    check_out();
    if (clr)     cnt = 3'd0;
    else if (en) cnt = cnt + 3'd1;
  endtask

  // One tracked edge with legal counter behaviour; expectations from the
  // counter model: the monitor shows the value present before the edge.
  task automatic step_model(input logic en);
    logic       w;
    logic [2:0] b;
    b = cnt;
    w = (last == 3'd7) && (cnt == 3'd0);
    if (w && (exp_wc != 8'hFF)) exp_wc = exp_wc + 8'd1;
    drive_step(en, 1'b0, pack(b, w, exp_wc, 1'b1, 1'b0));
    last = b;
  endtask

  // First edge after Reset/Clear: capture without check.
  task automatic relock();
    drive_step(1'b1, 1'b0, pack(cnt, 1'b0, 8'd0, 1'b1, 1'b0));
    last   = 3'd0;
    exp_wc = 8'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    cnt    = 3'd0;
    last   = 3'd0;
    exp_wc = 8'd0;
    En     = 1'b0;
    Clear  = 1'b0;
    Reset  = 1'b1;

    // Reset state
    #1;
    check_now(pack(3'd0, 1'b0, 8'd0, 1'b0, 1'b0));
    checks++;
    assert (dbg_state === 2'd0) else begin
      errors++;
      $error("FAIL reset_state: got %0d required 0", dbg_state);
    end
    Reset = 1'b0;

    // 1: ten enabled edges -> 0..7,0,1 with one wrap
    relock();
    for (int i = 0; i < 9; i++) step_model(1'b1);

    // 2: pause then resume -> Binary holds
    step_model(1'b1);
    step_model(1'b1);
    for (int i = 0; i < 3; i++) step_model(1'b0);
    for (int i = 0; i < 2; i++) step_model(1'b1);

    // 3: jump 001 -> 010 (binary 1 -> 3) while enabled
    for (int i = 0; i < 16; i++) begin
      if ((last == 3'd1) && (cnt == 3'd2)) break;
      step_model(1'b1);
    end
    cnt = 3'd3;
    drive_step(1'b1, 1'b0, pack(3'd3, 1'b0, exp_wc, 1'b0, 1'b1));
    // Sticky for five more edges, through a 7 -> 0 step without a wrap pulse
    for (int i = 0; i < 5; i++)
      drive_step(1'b1, 1'b0, pack(cnt, 1'b0, exp_wc, 1'b0, 1'b1));

    // 5: Clear with En in ERROR -> IDLE, counters cleared, relock next edge
    drive_step(1'b1, 1'b1, pack(cnt, 1'b0, 8'd0, 1'b0, 1'b0));
    relock();
    for (int i = 0; i < 3; i++) step_model(1'b1);

    // 4: Gray changes while the enable seen last edge was 0
    step_model(1'b0);
    step_model(1'b0);
    cnt = cnt + 3'd1;
    drive_step(1'b0, 1'b0, pack(cnt, 1'b0, exp_wc, 1'b0, 1'b1));
    drive_step(1'b0, 1'b1, pack(cnt, 1'b0, 8'd0, 1'b0, 1'b0));
    relock();
    for (int i = 0; i < 3; i++) step_model(1'b1);

    // Counter reset mid-count without Clear -> error next edge
    cnt = 3'd0;
    drive_step(1'b1, 1'b0, pack(3'd0, 1'b0, exp_wc, 1'b0, 1'b1));
    drive_step(1'b1, 1'b1, pack(cnt, 1'b0, 8'd0, 1'b0, 1'b0));
    relock();

    // Random enable pattern while tracking
    for (int i = 0; i < 200; i++) step_model(1'($urandom_range(0, 1)));

    // 6: reset pulse between edges mid-count
    #1;
    Reset = 1'b1;
    #1;
    check_now(pack(3'd0, 1'b0, 8'd0, 1'b0, 1'b0));
    #3;
    Reset = 1'b0;
    cnt   = 3'd0;
    #1;
    check_now(pack(3'd0, 1'b0, 8'd0, 1'b0, 1'b0));
    relock();

    // Saturation: more than 255 wraps, Wrap keeps pulsing at max
    for (int i = 0; i < 2070; i++) step_model(1'b1);
    checks++;
    assert (WrapCount === 8'hFF) else begin
      errors++;
      $error("FAIL saturate: got %0d required 255", WrapCount);
    end
    drive_step(1'b1, 1'b1, pack(cnt, 1'b0, 8'd0, 1'b0, 1'b0));

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: got %0d entries required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
